// File: rtl/board_uart_formatter.sv
// Serialises a DIM x DIM game board plus a win/tie status line into ASCII bytes for a UART TX FIFO.
// Optional macro TTT_FMT_TURN_EN adds a "Pn TURN" line for boards still in progress.
module board_uart_formatter #(
   parameter int DIM = 3,
   localparam int CELLS = DIM * DIM
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [2*CELLS-1:0]   cells,
   input  logic [1:0]           player_sel,
   input  logic [3:0]           game_state,
   input  logic                 fifo_full,
   output logic                 fifo_wr_en,
   output logic [7:0]           fifo_din,
   output logic                 busy,
   output logic                 done
);

   if (DIM < 2 || DIM > 4) begin : g_dim_check
      $error("board_uart_formatter: DIM must be in 2..4");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ROW   = 3'd1,
      S_BLANK = 3'd2,
      S_MSG   = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   localparam logic [2:0] LAST_COL = 3'(DIM);
   localparam logic [2:0] LAST_ROW = 3'(DIM - 1);
   localparam logic [4:0] DIM_W    = 5'(DIM);
   localparam logic [7:0] ASC_SP   = 8'h20;
   localparam logic [7:0] ASC_BAR  = 8'h7C;
   localparam logic [7:0] ASC_LF   = 8'h0A;
   localparam logic [7:0] ASC_CR   = 8'h0D;

   state_t             state_r, state_s;
   logic [2:0]         row_r, row_s, col_r, col_s;
   logic [3:0]         idx_r, idx_s;
   logic [2*CELLS-1:0] snap_cells_r;
   logic [1:0]         snap_player_r;
   logic [3:0]         snap_game_r;
   logic [7:0]         fifo_din_r, byte_s, digit_s;
   logic               busy_r, done_r;
   logic               emitting_s, accept_s, is_win_s, is_tie_s, msg_en_s;
   logic [3:0]         tok_last_s, msg_last_s;
   logic [4:0]         cell_k_s;
   logic [2*CELLS-1:0] shifted_s;
   logic [1:0]         code_s;

   // Empty cells show their own index so players can name a square.
   function automatic logic [7:0] glyph(input logic [1:0] code, input logic [4:0] k);
      case (code)
         2'd0:    glyph = (k < 5'd10) ? (8'h30 + {3'b000, k}) : (8'h37 + {3'b000, k});
         2'd1:    glyph = 8'h58;
         2'd2:    glyph = 8'h4F;
         default: glyph = 8'h3F;
      endcase
   endfunction

   function automatic logic [7:0] msg_byte(input logic tie, input logic win,
                                           input logic [7:0] digit, input logic [3:0] i);
      if (tie) begin
         case (i)
            4'd0:    msg_byte = 8'h54;
            4'd1:    msg_byte = 8'h49;
            4'd2:    msg_byte = 8'h45;
            4'd3:    msg_byte = ASC_LF;
            4'd4:    msg_byte = ASC_CR;
            4'd5:    msg_byte = ASC_LF;
            4'd6:    msg_byte = ASC_CR;
            default: msg_byte = 8'h00;
         endcase
      end else begin
         case (i)
            4'd0:    msg_byte = 8'h50;
            4'd1:    msg_byte = digit;
            4'd2:    msg_byte = ASC_SP;
            4'd3:    msg_byte = win ? 8'h57 : 8'h54;
            4'd4:    msg_byte = win ? 8'h49 : 8'h55;
            4'd5:    msg_byte = win ? 8'h4E : 8'h52;
            4'd6:    msg_byte = win ? 8'h53 : 8'h4E;
            4'd7:    msg_byte = ASC_LF;
            4'd8:    msg_byte = ASC_CR;
            4'd9:    msg_byte = ASC_LF;
            4'd10:   msg_byte = ASC_CR;
            default: msg_byte = 8'h00;
         endcase
      end
   endfunction

   assign emitting_s = (state_r == S_ROW) || (state_r == S_BLANK) || (state_r == S_MSG);
   assign fifo_wr_en = emitting_s & ~fifo_full;
   assign accept_s   = start && ((state_r == S_IDLE) || (state_r == S_FIN));
   assign is_win_s   = (snap_game_r == 4'd9);
   assign is_tie_s   = (snap_game_r == 4'd10);
   assign digit_s    = (snap_player_r == 2'd1) ? 8'h31 : 8'h32;
   assign msg_last_s = is_tie_s ? 4'd6 : 4'd10;
   // The first and the line-ending tokens of a row are 2 bytes; " | g" tokens are 4.
   assign tok_last_s = ((col_r == 3'd0) || (col_r == LAST_COL)) ? 4'd1 : 4'd3;
`ifdef TTT_FMT_TURN_EN
   assign msg_en_s   = 1'b1;
`else
   assign msg_en_s   = is_win_s | is_tie_s;
`endif

   // Next-state and position counters; the generator only moves on a consumed byte.
   always_comb begin
      state_s = state_r;
      row_s   = row_r;
      col_s   = col_r;
      idx_s   = idx_r;
      case (state_r)
         S_IDLE, S_FIN: begin
            row_s = 3'd0;
            col_s = 3'd0;
            idx_s = 4'd0;
            if (accept_s) state_s = S_ROW;
            else          state_s = S_IDLE;
         end
         S_ROW: begin
            if (!fifo_wr_en) begin
               state_s = S_ROW;
            end else if (idx_r != tok_last_s) begin
               idx_s = idx_r + 4'd1;
            end else begin
               idx_s = 4'd0;
               if (col_r != LAST_COL) begin
                  col_s = col_r + 3'd1;
               end else begin
                  col_s = 3'd0;
                  if (row_r != LAST_ROW) begin
                     row_s = row_r + 3'd1;
                  end else begin
                     row_s   = 3'd0;
                     state_s = S_BLANK;
                  end
               end
            end
         end
         S_BLANK: begin
            if (!fifo_wr_en) begin
               state_s = S_BLANK;
            end else if (idx_r == 4'd0) begin
               idx_s = 4'd1;
            end else begin
               idx_s   = 4'd0;
               state_s = msg_en_s ? S_MSG : S_FIN;
            end
         end
         S_MSG: begin
            if (!fifo_wr_en) begin
               state_s = S_MSG;
            end else if (idx_r != msg_last_s) begin
               idx_s = idx_r + 4'd1;
            end else begin
               idx_s   = 4'd0;
               state_s = S_FIN;
            end
         end
         default: begin
            state_s = S_IDLE;
            row_s   = 3'd0;
            col_s   = 3'd0;
            idx_s   = 4'd0;
         end
      endcase
   end

   // Byte at the next position; loaded into fifo_din on accept or on each consumed byte.
   always_comb begin
      cell_k_s  = ({2'b00, row_s} * DIM_W) + {2'b00, col_s};
      shifted_s = snap_cells_r >> {cell_k_s, 1'b0};
      code_s    = shifted_s[1:0];
      case (state_s)
         S_ROW: begin
            if (col_s == LAST_COL)                    byte_s = (idx_s == 4'd0) ? ASC_LF : ASC_CR;
            else if (idx_s == 4'd0 || idx_s == 4'd2)  byte_s = ASC_SP;
            else if (idx_s == 4'd1 && col_s != 3'd0)  byte_s = ASC_BAR;
            else                                      byte_s = glyph(code_s, cell_k_s);
         end
         S_BLANK: byte_s = (idx_s == 4'd0) ? ASC_LF : ASC_CR;
         S_MSG:   byte_s = msg_byte(is_tie_s, is_win_s, digit_s, idx_s);
         default: byte_s = 8'h00;
      endcase
   end

   // State, counters, input snapshot and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= S_IDLE;
         row_r         <= 3'd0;
         col_r         <= 3'd0;
         idx_r         <= 4'd0;
         snap_cells_r  <= '0;
         snap_player_r <= 2'd0;
         snap_game_r   <= 4'd0;
         fifo_din_r    <= 8'h00;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r <= state_s;
         row_r   <= row_s;
         col_r   <= col_s;
         idx_r   <= idx_s;
         if (accept_s) begin
            snap_cells_r  <= cells;
            snap_player_r <= player_sel;
            snap_game_r   <= game_state;
         end
         if (accept_s || fifo_wr_en) fifo_din_r <= byte_s;
         busy_r <= (state_s == S_ROW) || (state_s == S_BLANK) || (state_s == S_MSG);
         done_r <= (state_s == S_FIN);
      end
   end

   assign fifo_din = fifo_din_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule

// File: tb/tb_board_uart_formatter.sv
// Directed self-checking bench for board_uart_formatter (DIM=3 and DIM=4 instances).
module tb_board_uart_formatter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0, start4 = 1'b0, fifo_full = 1'b0, sel4 = 1'b0;
   logic [17:0] cells = '0;
   logic [31:0] cells4 = '0;
   logic [1:0]  player_sel = 2'd0;
   logic [3:0]  game_state = 4'd0;
   logic        wr3, busy3, done3, wr4, busy4, done4;
   logic [7:0]  din3, din4;

   int n_checks = 0;
   int n_err = 0;
   logic [7:0] cap[$];
   int cyc = 0, done_cnt = 0, wr_full = 0, wr_rst = 0, last_wr_cyc = 0, done_cyc = 0;
   int base, n;

   string E38   = " 0 | 1 | 2\n\r 3 | 4 | 5\n\r 6 | 7 | 8\n\r\n\r";
   string EWIN  = " X | O | X\n\r 3 | X | 5\n\r O | 7 | X\n\r\n\rP1 WINS\n\r\n\r";
   string EWIN2 = " X | O | X\n\r 3 | X | 5\n\r O | 7 | X\n\r\n\rP2 WINS\n\r\n\r";
   string ETIE  = " O | X | ?\n\r 3 | 4 | 5\n\r 6 | 7 | 8\n\r\n\rTIE\n\r\n\r";
   string E66   = " 0 | 1 | 2 | 3\n\r 4 | 5 | 6 | 7\n\r 8 | 9 | A | B\n\r C | D | E | F\n\r\n\r";

   localparam logic [31:0] WIN_BOARD = {14'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1};
   localparam logic [31:0] TIE_BOARD = {14'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd2};

   always #5 clk = ~clk;

   board_uart_formatter #(.DIM(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .start(start), .cells(cells),
      .player_sel(player_sel), .game_state(game_state), .fifo_full(fifo_full),
      .fifo_wr_en(wr3), .fifo_din(din3), .busy(busy3), .done(done3)
   );

   board_uart_formatter #(.DIM(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .cells(cells4),
      .player_sel(player_sel), .game_state(game_state), .fifo_full(fifo_full),
      .fifo_wr_en(wr4), .fifo_din(din4), .busy(busy4), .done(done4)
   );

   function automatic logic       o_wr();   return sel4 ? wr4 : wr3;     endfunction
   function automatic logic       o_busy(); return sel4 ? busy4 : busy3; endfunction
   function automatic logic       o_done(); return sel4 ? done4 : done3; endfunction
   function automatic logic [7:0] o_din();  return sel4 ? din4 : din3;   endfunction

   // Byte capture and event bookkeeping on the inactive edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (o_wr()) begin
         cap.push_back(o_din());
         last_wr_cyc <= cyc;
         if (fifo_full) wr_full <= wr_full + 1;
         if (!reset_n)  wr_rst <= wr_rst + 1;
      end
      if (o_done()) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_stream(input string tag, input string exp, input int b);
      chk({tag, " length"}, cap.size() - b, exp.len());
      for (int i = 0; i < exp.len(); i++) begin
         if (b + i < cap.size()) chk($sformatf("%s byte%0d", tag, i), cap[b + i], exp[i]);
      end
   endtask

   // mode: 0 free-running, 1 fifo_full toggling, 2 full held on the last byte, 3 mid-stream poke
   task automatic stream(input string tag, input logic [31:0] c, input logic [1:0] ps,
                         input logic [3:0] gs, input int mode, input string exp);
      int b, bdone, k, hold;
      bit poked;
      fifo_full = 1'b0;
      cells = c[17:0]; cells4 = c; player_sel = ps; game_state = gs;
      b = cap.size(); bdone = done_cnt;
      @(posedge clk); #1;
      if (sel4) start4 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start4 = 1'b0;
      chk({tag, " busy_rise"}, o_busy(), 1);
      chk({tag, " first_byte"}, o_din(), 8'h20);
      chk({tag, " first_wr"}, o_wr(), 1);
      k = 0; hold = 0; poked = 1'b0;
      while (done_cnt == bdone && k < 400) begin
         @(posedge clk); #1;
         k++;
         start = 1'b0;
         case (mode)
            1: fifo_full = ((k / 3) % 2 == 0);
            2: begin
               if (cap.size() - b == exp.len() - 1 && hold < 4) begin
                  fifo_full = 1'b1;
                  hold++;
               end else begin
                  fifo_full = 1'b0;
               end
            end
            3: begin
               if (!poked && cap.size() - b == 10) begin
                  poked = 1'b1;
                  start = 1'b1;
                  cells = ~c[17:0];
                  player_sel = 2'd1;
                  game_state = 4'd10;
               end
            end
            default: fifo_full = 1'b0;
         endcase
      end
      fifo_full = 1'b0; start = 1'b0;
      chk({tag, " done_seen"}, done_cnt != bdone, 1);
      chk({tag, " done_gap"}, done_cyc - last_wr_cyc, 1);
      chk({tag, " busy_fall"}, o_busy(), 0);
      chk({tag, " done_width"}, o_done(), 0);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, " done_count"}, done_cnt - bdone, 1);
      chk({tag, " wr_while_full"}, wr_full, 0);
      cmp_stream(tag, exp, b);
   endtask

   initial begin
      #12;
      chk("rst wr_en", wr3, 0);
      chk("rst din", din3, 8'h00);
      chk("rst busy", busy3, 0);
      chk("rst done", done3, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle wr_en", wr3, 0);

      stream("empty38", 32'd0, 2'd0, 4'd0, 0, E38);
      stream("win49", WIN_BOARD, 2'd1, 4'd9, 0, EWIN);
      stream("tie45_full", TIE_BOARD, 2'd2, 4'd10, 1, ETIE);
      stream("poke49", WIN_BOARD, 2'd3, 4'd9, 3, EWIN2);
      stream("hold_last", 32'd0, 2'd0, 4'd5, 2, E38);

      // Abort a stream with reset at byte 20, then print again from byte 0.
      cells = '0; game_state = 4'd0; base = cap.size();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (cap.size() - base < 20 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_mid reached", cap.size() - base >= 20, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid wr_en", wr3, 0);
      chk("rst_mid din", din3, 8'h00);
      chk("rst_mid busy", busy3, 0);
      chk("rst_mid done", done3, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid hold wr_en", wr3, 0);
      chk("rst_mid hold busy", busy3, 0);
      reset_n = 1'b1;
      chk("rst_mid writes", wr_rst, 0);
      stream("after_rst", 32'd0, 2'd0, 4'd0, 0, E38);

      sel4 = 1'b1;
      @(posedge clk); #1;
      stream("dim4_66", 32'd0, 2'd0, 4'd0, 0, E66);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
